// File: rtl/wb_line_mem_responder_pkg.sv
// rtl/wb_line_mem_responder_pkg.sv - shared state encoding, default widths and line type
package wb_mem_pkg;

  localparam int DEFAULT_LINE_W = 256;
  localparam int DEFAULT_ADDR_W = 27;

  typedef enum logic [1:0] {IDLE, WAIT, RESP, DONE} state_t;

  typedef logic [DEFAULT_LINE_W-1:0] line_t;

endpackage

// File: rtl/wb_line_mem_responder_if.sv
// rtl/wb_line_mem_responder_if.sv - cache-line memory bus between L2 initiator and memory responder
interface wb_line_mem_responder_if
  import wb_mem_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int LINE_W = DEFAULT_LINE_W
);
  logic              mem_cyc;
  logic              mem_stb;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_adr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              mem_rty;

  modport master (
    output mem_cyc, mem_stb, mem_we, mem_adr, mem_wdata,
    input  mem_rdata, mem_ack, mem_rty
  );

  modport slave (
    input  mem_cyc, mem_stb, mem_we, mem_adr, mem_wdata,
    output mem_rdata, mem_ack, mem_rty
  );
endinterface

// File: rtl/wb_line_mem_responder_line_ram.sv
// rtl/wb_line_mem_responder_line_ram.sv - single-port line array, synchronous write, combinational read
module line_ram #(
  parameter  int LINE_W = 256,
  parameter  int DEPTH  = 1024,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);
  logic [LINE_W-1:0] mem [DEPTH];

  // commit a full line on the write strobe; contents survive reset
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];
endmodule

// File: rtl/wb_line_mem_responder.sv
// rtl/wb_line_mem_responder.sv - fixed-latency line memory responder; WB_MEM_RTY_INJECT_EN enables retry injection
module wb_line_mem_responder
  import wb_mem_pkg::*;
#(
  parameter int LINE_W     = DEFAULT_LINE_W,
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 4,
  parameter int RTY_PERIOD = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  wb_line_mem_responder_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);

  state_t            state;
  logic [3:0]        lat_cnt;
  logic              we_q;
  logic [IDX_W-1:0]  idx_q;
  logic [LINE_W-1:0] wdata_q;
  logic              rty_q;

  logic              req;
  logic              rty_hit;
  logic              resp_we;
  logic              resp_rty;
  logic [IDX_W-1:0]  ram_idx;
  logic              ram_we;
  logic [LINE_W-1:0] ram_rdata;

  assign req = bus.mem_cyc && bus.mem_stb;

`ifdef WB_MEM_RTY_INJECT_EN
  logic [3:0] rty_cnt;
  assign rty_hit = (rty_cnt == 4'(RTY_PERIOD - 1));

  // count acceptances; the one that lands on RTY_PERIOD-1 is retried and wraps the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rty_cnt <= '0;
    else if (state == IDLE && req) rty_cnt <= rty_hit ? 4'd0 : rty_cnt + 4'd1;
  end
`else
  assign rty_hit = 1'b0;
`endif

  // in IDLE the live request feeds the response path so LATENCY=1 can answer immediately
  assign resp_we  = (state == IDLE) ? bus.mem_we  : we_q;
  assign resp_rty = (state == IDLE) ? rty_hit     : rty_q;
  assign ram_idx  = (state == IDLE) ? bus.mem_adr[IDX_W-1:0] : idx_q;
  assign ram_we   = (state == RESP) && we_q && !rty_q;

  line_ram #(.LINE_W(LINE_W), .DEPTH(DEPTH)) u_line_ram (
    .clk   (clk),
    .we    (ram_we),
    .idx   (ram_idx),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // request FSM with registered ack/rty/rdata; outputs pulse for exactly the RESP cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      lat_cnt       <= '0;
      we_q          <= 1'b0;
      idx_q         <= '0;
      wdata_q       <= '0;
      rty_q         <= 1'b0;
      bus.mem_ack   <= 1'b0;
      bus.mem_rty   <= 1'b0;
      bus.mem_rdata <= '0;
    end else begin
      bus.mem_ack   <= 1'b0;
      bus.mem_rty   <= 1'b0;
      bus.mem_rdata <= '0;
      case (state)
        IDLE: begin
          if (req) begin
            we_q    <= bus.mem_we;
            idx_q   <= bus.mem_adr[IDX_W-1:0];
            wdata_q <= bus.mem_wdata;
            rty_q   <= rty_hit;
            lat_cnt <= 4'(LATENCY - 1);
            if (LATENCY == 1) begin
              state         <= RESP;
              bus.mem_ack   <= !resp_rty;
              bus.mem_rty   <= resp_rty;
              bus.mem_rdata <= (resp_we || resp_rty) ? '0 : ram_rdata;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!req) begin
            state <= IDLE;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
            if (lat_cnt == 4'd1) begin
              state         <= RESP;
              bus.mem_ack   <= !resp_rty;
              bus.mem_rty   <= resp_rty;
              bus.mem_rdata <= (resp_we || resp_rty) ? '0 : ram_rdata;
            end
          end
        end
        RESP: state <= rty_q ? IDLE : DONE;
        DONE: if (!bus.mem_stb) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/wb_line_mem_responder.md
Name: wb_line_mem_responder

Overview:
- Responder (slave) end of the cache-line memory bus driven by the L2 cache controller: accepts cyc/stb/we requests, serves 256-bit line reads/writes from an internal array after a fixed latency, returns a single-cycle ack.
- Serves as the synthesizable physical-memory model behind the L2 for simulation and FPGA bring-up.
- Optional retry injection exercises the initiator's rty path.

Parameters:
- LINE_W, 256, data width of one cache line in bits.
- ADDR_W, 27, line-address width (byte address bits 31:5).
- DEPTH, 1024, number of lines in the array; power of two.
- LATENCY, 4, cycles from request acceptance to ack; legal range 1..15.
- RTY_PERIOD, 3, every RTY_PERIOD-th accepted request is retried (used only with the macro); legal range ≥2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- mem_cyc  in  1  bus cycle valid.
- mem_stb  in  1  request strobe.
- mem_we  in  1  1 = write line, 0 = read line.
- mem_adr  in  ADDR_W  line address.
- mem_wdata  in  LINE_W  write data; sampled at acceptance.
- mem_rdata  out  LINE_W  read data; valid only while mem_ack is high on a read.
- mem_ack  out  1  single-cycle completion pulse.
- mem_rty  out  1  single-cycle retry pulse; always 0 without the macro.

Behaviour:
- Reset: state=IDLE, mem_ack=0, mem_rty=0, mem_rdata=0, latency counter=0, retry counter=0. Array contents are not reset. Reset asserted mid-transaction aborts it with no write commit.
- Index: mem_adr[log2(DEPTH)-1:0]; upper bits ignored, so addresses alias modulo DEPTH.
- States: IDLE, WAIT, RESP, DONE.
- IDLE: on cyc&stb, latch we, index and wdata; load counter=LATENCY-1; go to WAIT. If LATENCY=1, go directly to RESP.
- WAIT: decrement the counter each cycle; at 0, go to RESP.
- Abort: if cyc or stb is low in WAIT, return to IDLE with no ack and no write.
- RESP (one cycle): mem_ack=1.
  - Read: mem_rdata=array[index].
  - Write: array[index] is updated on this clock edge.
  - Go to DONE.
- Ack timing: with stb first sampled high at edge N, mem_ack is high during the cycle after edge N+LATENCY-1, i.e. LATENCY cycles after acceptance.
- DONE: wait for stb=0, then go to IDLE. A new request therefore needs stb deasserted for at least one cycle, matching the initiator's allocate→idle and write_back→strobe sequencing.
- Request fields are latched, so changes to mem_adr/mem_wdata/mem_we after acceptance are ignored.
- mem_ack and mem_rty are never high together; neither is high for more than one consecutive cycle.
- Back-to-back write then read to the same line returns the new data.

Optional Feature:
- Macro: WB_MEM_RTY_INJECT_EN.
- Defined:
  - A 4-bit retry counter increments on every acceptance.
  - When the count reaches RTY_PERIOD-1, it clears and that request ends in RESP with mem_rty=1 instead of mem_ack: no write, mem_rdata=0.
  - After a retry, go to IDLE (not DONE), so a still-high stb is re-accepted next cycle as a fresh request.
  - Since the counter has just cleared, the re-issued request is not retried again.
- Undefined: no retry counter; mem_rty tied to 0.

Decomposition:
- Package wb_mem_pkg:
  - state enum (IDLE, WAIT, RESP, DONE).
  - LINE_W and ADDR_W default constants.
  - Line-data typedef logic [LINE_W-1:0].
- Sub-module line_ram holds the array: single-port, synchronous write, combinational read, parameters LINE_W and DEPTH.
- The FSM, latency counter and retry counter stay in wb_line_mem_responder.

Test Plan:
- Reset mid-WAIT:
  - Assert rst two cycles after a write request to line 0x5.
  - Required: ack stays 0.
  - Required: a later read of 0x5 returns the prior contents.
- Write then read, LATENCY=4:
  - Write 0xA5…A5 to line 0x10; ack exactly 4 cycles after acceptance, lasting 1 cycle.
  - Drop stb for 1 cycle, then read 0x10.
  - Required: rdata=0xA5…A5 with ack.
- Aliasing, DEPTH=1024:
  - Write 0x1 to line 0x7, then 0x2 to line 0x407.
  - Required: a read of 0x7 returns 0x2.
- Abort:
  - Drop cyc at cycle 2 of a write to line 0x20.
  - Required: no ack; line 0x20 is unchanged.
- Stb held after ack:
  - Keep stb high 5 cycles after ack.
  - Required: no second ack until stb falls and re-rises.
- With WB_MEM_RTY_INJECT_EN, RTY_PERIOD=3:
  - Issue 3 reads; the third gets rty=1, ack=0.
  - Hold stb high.
  - Required: re-accepted next cycle; ack after LATENCY with correct data.
